// File: rtl/hs_pkg.sv
// Shared types and constants for the four-phase request/accept link.
// The state encoding is exported as plain localparams so receiver-side benches can decode it.
package hs_pkg;

  localparam logic [1:0] HS_TX_IDLE  = 2'd0;
  localparam logic [1:0] HS_TX_REQ   = 2'd1;
  localparam logic [1:0] HS_TX_REL   = 2'd2;
  localparam logic [1:0] HS_TX_ABORT = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = HS_TX_IDLE,
    REQ   = HS_TX_REQ,
    REL   = HS_TX_REL,
    ABORT = HS_TX_ABORT
  } hs_tx_state_t;

  // The timer only ever holds 0..timeout-1, so clog2 bits are enough.
  function automatic int hs_timer_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/hs_fifo.sv
// Small circular-buffer FIFO with a separate occupancy counter.
// A full FIFO refuses pushes even when a pop happens in the same cycle.
module hs_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hs_req_tx.sv
// Four-phase request initiator: drains a local FIFO onto R/D, waits for A, returns to zero.
// A receiver that never answers is abandoned after TIMEOUT cycles and the word is retried.
module hs_req_tx
  import hs_pkg::*;
#(
  parameter int W       = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_valid,
  input  logic [W-1:0]           in_data,
  output logic                   in_ready,
  output logic                   R,
  output logic [W-1:0]           D,
  input  logic                   A,
  output logic [$clog2(DEPTH):0] count,
  output logic                   tmo,
  output logic                   busy
);

  localparam int TW = hs_timer_width(TIMEOUT);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  hs_tx_state_t  state;
  logic [TW-1:0] timer;
  logic [W-1:0]  head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;

  assign in_ready = ~fifo_full;
  assign busy     = (state != IDLE);
  assign pop      = (state == REQ) & A;

  hs_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Accept wins over timeout when both land on the same REQ cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      R     <= 1'b0;
      D     <= '0;
      tmo   <= 1'b0;
      timer <= '0;
    end else begin
      tmo <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty && !A) begin
            state <= REQ;
            R     <= 1'b1;
            D     <= head;
            timer <= '0;
          end
        end
        REQ: begin
          if (A) begin
            state <= REL;
            R     <= 1'b0;
            timer <= '0;
          end else if (timer == TMR_LAST) begin
            state <= ABORT;
            R     <= 1'b0;
            tmo   <= 1'b1;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        REL: begin
          if (!A) begin
            state <= IDLE;
          end
        end
        ABORT: begin
          if (!A) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_req_tx.sv
// Directed bench for hs_req_tx: handshake, FIFO fill/wrap, timeout, late accept and async reset.
module tb_hs_req_tx;

  localparam int W       = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic                   CLK = 1'b0;
  logic                   RST;
  logic                   in_valid;
  logic [W-1:0]           in_data;
  logic                   in_ready;
  logic                   R;
  logic [W-1:0]           D;
  logic                   A;
  logic [$clog2(DEPTH):0] count;
  logic                   tmo;
  logic                   busy;

  int checkCount = 0;
  int errorCount = 0;

  hs_req_tx #(
    .W       (W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .R        (R),
    .D        (D),
    .A        (A),
    .count    (count),
    .tmo      (tmo),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive inputs just after an edge, let one rising edge pass, then sample.
  task automatic applyStimulus(input logic valid, input logic [W-1:0] data, input logic accept);
    in_valid = valid;
    in_data  = data;
    A        = accept;
    @(posedge CLK);
    #1;
  endtask

  // Receiver side of one complete four-phase transfer.
  task automatic serveWord(input string tag, input logic [W-1:0] expData, input int expCount);
    for (int i = 0; i < 4 && !R; i++) applyStimulus(1'b0, '0, 1'b0);
    checkOutput({tag, "_r_rise"}, 32'(R), 32'd1);
    checkOutput({tag, "_data"}, 32'(D), 32'(expData));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput({tag, "_r_fall"}, 32'(R), 32'd0);
    checkOutput({tag, "_count"}, 32'(count), 32'(expCount));
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errorCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int highCycles;
    RST = 1'b1; in_valid = 1'b0; in_data = '0; A = 1'b0;
    #2;
    checkOutput("rst_r", 32'(R), 32'd0);
    checkOutput("rst_d", 32'(D), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_tmo", 32'(tmo), 32'd0);
    #20 RST = 1'b0;
    @(posedge CLK); #1;

    $display("[TB] single word 0xA5");
    applyStimulus(1'b1, 8'hA5, 1'b0);
    checkOutput("a5_count1", 32'(count), 32'd1);
    checkOutput("a5_r_low", 32'(R), 32'd0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("a5_r_rise", 32'(R), 32'd1);
    checkOutput("a5_data", 32'(D), 32'hA5);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("a5_r_fall", 32'(R), 32'd0);
    checkOutput("a5_count0", 32'(count), 32'd0);
    checkOutput("a5_rel_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("a5_idle", 32'(busy), 32'd0);
    checkOutput("a5_d_hold", 32'(D), 32'hA5);

    $display("[TB] burst 01..05 into depth 4");
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, W'(i), 1'b0);
      checkOutput($sformatf("burst_count%0d", i), 32'(count), 32'((i < 4) ? i : 4));
      checkOutput($sformatf("burst_ready%0d", i), 32'(in_ready), 32'((i < 4) ? 1 : 0));
    end
    in_valid = 1'b0;
    serveWord("burst01", 8'h01, 3);
    serveWord("burst02", 8'h02, 2);
    serveWord("burst03", 8'h03, 1);
    serveWord("burst04", 8'h04, 0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("burst_no05", 32'(R), 32'd0);

    $display("[TB] two 3-word bursts across the pointer wrap");
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, W'(8'h10 * (j + 1) + k), 1'b0);
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++)
        serveWord($sformatf("wrap%0d_%0d", j, k), W'(8'h10 * (j + 1) + k), 2 - k);
    end

    $display("[TB] timeout with A held low");
    applyStimulus(1'b1, 8'h5A, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    highCycles = 0;
    while (R && highCycles < 40) begin
      highCycles++;
      applyStimulus(1'b0, '0, 1'b0);
    end
    checkOutput("tmo_r_cycles", 32'(highCycles), 32'(TIMEOUT));
    checkOutput("tmo_pulse", 32'(tmo), 32'd1);
    checkOutput("tmo_r_low", 32'(R), 32'd0);
    checkOutput("tmo_count", 32'(count), 32'd1);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("tmo_single", 32'(tmo), 32'd0);
    checkOutput("tmo_idle", 32'(busy), 32'd0);
    serveWord("tmo_retry", 8'h5A, 0);

    $display("[TB] late accept in first ABORT cycle");
    applyStimulus(1'b1, 8'h3C, 1'b0);
    for (int i = 0; i < 40 && !tmo; i++) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("late_tmo", 32'(tmo), 32'd1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("late_abort1", 32'(busy), 32'd1);
    checkOutput("late_r", 32'(R), 32'd0);
    checkOutput("late_nopop", 32'(count), 32'd1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("late_abort2", 32'(busy), 32'd1);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("late_idle", 32'(busy), 32'd0);
    checkOutput("late_count", 32'(count), 32'd1);
    serveWord("late_retry", 8'h3C, 0);

    $display("[TB] A already high in IDLE");
    applyStimulus(1'b1, 8'h77, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("ahigh_r0", 32'(R), 32'd0);
    checkOutput("ahigh_idle", 32'(busy), 32'd0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("ahigh_r1", 32'(R), 32'd0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("ahigh_rise", 32'(R), 32'd1);
    serveWord("ahigh", 8'h77, 0);

    $display("[TB] async reset mid-REQ");
    applyStimulus(1'b1, 8'h21, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 8'h23, 1'b0);
    in_valid = 1'b0;
    checkOutput("mid_count3", 32'(count), 32'd3);
    checkOutput("mid_r", 32'(R), 32'd1);
    #2 RST = 1'b1;
    #1;
    checkOutput("arst_r", 32'(R), 32'd0);
    checkOutput("arst_d", 32'(D), 32'd0);
    checkOutput("arst_count", 32'(count), 32'd0);
    checkOutput("arst_ready", 32'(in_ready), 32'd1);
    #10 RST = 1'b0;
    @(posedge CLK); #1;
    applyStimulus(1'b1, 8'h99, 1'b0);
    in_valid = 1'b0;
    checkOutput("post_count", 32'(count), 32'd1);
    serveWord("post", 8'h99, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/hs_req_tx.md
# hs_req_tx

Upstream initiator for the four-phase request/accept link. It buffers words from a local producer in a small FIFO and presents each one on `D` with request `R`. It waits for accept `A`, then completes the return-to-zero phase before offering the next word. This block drives the `R`/`A` pair that the downstream handshake logic consumes. It also adds a timeout so that a silent receiver cannot hang the producer.

## Interface
- `W`, 8, data width
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `TIMEOUT`, 16, max cycles in REQ waiting for `A`; ≥2
- `CLK`  in  1  single clock, rising edge
- `RST`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  producer has a word
- `in_data`  in  W  producer word
- `in_ready`  out  1  FIFO can accept; push = `in_valid & in_ready`
- `R`  out  1  request to receiver (registered)
- `D`  out  W  data accompanying `R`, stable while `R`=1 (registered)
- `A`  in  1  accept from receiver, synchronous to `CLK`
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy
- `tmo`  out  1  one-cycle pulse on timeout abort
- `busy`  out  1  FSM not in IDLE

## Operation
- FIFO
  - Circular buffer with `rd_ptr` and `wr_ptr`, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - `count` is a separate counter.
  - `in_ready = (count != DEPTH)`. There is no pass-through when full; a pop in the same cycle does not raise `in_ready`.
  - A push and a pop in the same cycle leave `count` unchanged.
- FSM states: IDLE, REQ, REL, ABORT
  - IDLE: if `count>0` → REQ. `D` loads the head entry and `R` is set to 1 on the same edge.
  - REQ: `R`=1, and the timer increments every cycle.
    - If `A`=1 is sampled → REL. `R` is cleared, the head is popped, and the timer clears.
    - If the timer reaches TIMEOUT-1 with `A`=0 → ABORT. `R` is cleared and `tmo` pulses. The head is not popped, so it is retried.
  - REL: `R`=0. Wait for `A`=0 sampled → IDLE.
  - ABORT: `R`=0. Wait for `A`=0 sampled → IDLE. This covers an `A` that rises late.
- `A`=1 seen in IDLE is ignored and stays there until it is low. IDLE→REQ requires `A`=0 sampled in the same cycle.
- `D` changes only on the IDLE→REQ edge. It holds its value at all other times, including after `R` falls.
- Reset, asynchronous:
  - `R`=0, `D`=0, `tmo`=0, state IDLE
  - pointers, `count` and timer are 0, so `in_ready`=1
  - Mid-transfer reset drops `R` immediately and discards all FIFO contents.

## Timing
- Latency from a push into an empty FIFO (edge N) to `R`=1 is 1 cycle: IDLE sees `count`=1 at N+1 and `R` rises after edge N+1.
- Minimum transfer is 4 cycles: IDLE→REQ, REQ (A sampled), REL (A low sampled), IDLE.
- Back-to-back words cost one IDLE cycle between `R` pulses.
- `R` falls on the edge after `A` is first sampled high.
- A timeout fires exactly TIMEOUT cycles after `R` rose. `tmo` is high during the first cycle of ABORT.
- `count`, `in_ready` and `busy` reflect registered state. `busy` is a decode of the state register.

## Structure
- Shared package `hs_pkg` holds:
  - the state enum `hs_tx_state_t` (IDLE=0, REQ=1, REL=2, ABORT=3)
  - the timer width function
  - localparams for the state encoding reused by the receiver bench
- One sub-module, `hs_fifo`: parameterised W/DEPTH storage with push/pop/count/full/empty.
- The top level holds the FSM, the timer and the `R`/`D` registers.

## Test plan
- Reset, then push 0xA5 with `A` tied to follow `R` one cycle late.
  - Required: `R` rises 1 cycle after the push and `D`=0xA5.
  - Required: `R` falls 1 cycle after `A`, returns to IDLE, `count` goes 1→0.
- Burst of 0x01..0x04 pushed every cycle with `DEPTH`=4.
  - Required: `in_ready` drops when `count`=4 and a 5th push is refused.
  - Required: the words leave in order 01, 02, 03, 04, and pointers wrap correctly on a subsequent 3-word burst.
- `A` held 0 with `TIMEOUT`=16.
  - Required: `R` stays high exactly 16 cycles, then `tmo` pulses once and `R`=0.
  - Required: the same word is re-offered after IDLE, and `count` is unchanged.
- `A` asserted late, in the first ABORT cycle.
  - Required: the FSM stays in ABORT until `A`=0, there is no pop, and the retry then completes normally.
- `A`=1 already high while IDLE with data pending.
  - Required: `R` stays 0 until `A` is sampled low, then the transfer proceeds.
- Assert `RST` asynchronously mid-REQ with 3 words queued.
  - Required: `R`, `D` and `count` go to 0 immediately without a clock edge, and `in_ready`=1.
  - Required: after release, a new push transfers correctly.
